owm_byte_seq: RTL and testbench
===============================

# owm_byte_seq

Byte/triplet sequencer sitting directly upstream of the 1-wire bit-level master core. Accepts byte-level requests (bus reset, write byte, read byte, ROM-search triplet) over a valid/ready request channel. Breaks each request into single-bit core commands and returns one response per request. It drives the core's start/cmd/wrdat inputs and consumes its ready/rddat/presence outputs.

## Interface
Parameters:
- none (byte width fixed at 8; core command codes fixed below)

Ports:
- clk_i  in  1  single clock; everything is sampled on its rising edge
- rst_i  in  1  reset, asynchronous and active-high
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when valid && ready
- req_op_i  in  2  request op: 00 bus reset, 01 write byte, 10 read byte, 11 search triplet
- req_data_i  in  8  byte to write (op 01); bit 0 = search direction (op 11)
- rsp_valid_o  out  1  response valid, held until taken
- rsp_ready_i  in  1  response taken when valid && ready
- rsp_data_o  out  8  response payload, format per op below
- rsp_presence_o  out  1  presence result (op 00 only; 0 for other ops)
- owm_start_o  out  1  one-cycle pulse that starts a core command
- owm_cmd_o  out  3  core command: 3'd0 reset/presence, 3'd1 write bit, 3'd2 read bit
- owm_wrdat_o  out  1  bit to write (cmd 1)
- owm_ready_i  in  1  core idle
- owm_presence_i  in  1  presence result, valid when ready_i returns high after cmd 0
- owm_rddat_i  in  1  read bit, valid when ready_i returns high after cmd 2

## Operation
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP.
- IDLE: req_ready_o=1. On handshake, latch op, data and direction; clear bit counter and shift register; go to ISSUE.
- ISSUE: when owm_ready_i=1, pulse owm_start_o for one cycle with cmd/wrdat for the current bit, then go to WAIT_BUSY. If owm_ready_i=0, stay in ISSUE.
- WAIT_BUSY: wait for owm_ready_i=0, then go to WAIT_DONE.
- WAIT_DONE: wait for owm_ready_i=1. Sample rddat_i or presence_i on that cycle. Then either go back to ISSUE for the next bit or go to RESP.
- RESP: rsp_valid_o=1; outputs stable. On rsp_ready_i=1, go to IDLE.
- Op 00: one cmd 0. rsp_data_o=8'h00, rsp_presence_o=presence sample.
- Op 01: 8 cmd 1 bits, LSB first, wrdat=req_data_i[bit]. rsp_data_o echoes the written byte.
- Op 10: 8 cmd 2 bits, LSB first. Read bit k goes into rsp_data_o[k] (right-shift register fill from bit 7).
- Op 11, three steps:
  - read id bit a, then read complement bit b.
  - ab=01 → write 0; ab=10 → write 1; ab=00 → write direction; ab=11 → no write (error).
  - rsp_data_o = {4'b0, err, dir_taken, b, a}; err=1 only for ab=11, and dir_taken=0 in that case.
- Bit counter is 3 bits. The last bit is detected at count 7, so there is no wrap into a 9th bit.
- Reset (any time, including mid-byte): FSM to IDLE; owm_start_o=0, owm_cmd_o=0, owm_wrdat_o=0, rsp_valid_o=0, rsp_data_o=0, rsp_presence_o=0, req_ready_o=1 (combinational from IDLE). Partial bytes are discarded; no response is emitted for them.

## Timing
- Request accepted at edge N → owm_start_o high during cycle N+1 if owm_ready_i=1.
- Exactly one start pulse per bit. owm_start_o is never asserted while owm_ready_i=0 or in WAIT_BUSY/WAIT_DONE.
- owm_cmd_o and owm_wrdat_o are registered and valid in the start-pulse cycle. Both hold until the next ISSUE.
- Next bit's start comes 1 cycle after ready_i rises (WAIT_DONE→ISSUE→pulse).
- rsp_valid_o rises 1 cycle after the final ready_i rise.
- Overhead per request = 3 + 2·bits cycles beyond core bit time.
- req_valid_i is ignored outside IDLE. A response must be taken before the next request is accepted, so there is no overlap.
- rsp_ready_i high in the same cycle rsp_valid_o rises completes the handshake at that edge; IDLE follows next cycle.

## Test plan
- Reset sequence: op 00 with the core model returning presence=1 → one start with cmd 0; rsp_presence_o=1, rsp_data_o=8'h00. Repeat with presence=0 → rsp_presence_o=0.
- Write byte: op 01, req_data_i=8'hA5 → 8 starts, cmd 1, wrdat sequence 1,0,1,0,0,1,0,1; rsp_data_o=8'hA5.
- Read byte: op 10, core returns bits 0,1,1,0,0,0,1,1 → rsp_data_o=8'hC6. Also check no start is issued while ready_i=0 (core holds busy for random 1–20 cycles).
- Triplet, one case per (ab, dir) pair:
  - ab=10, dir=0 → write 1, rsp 8'h05.
  - ab=01 → write 0, rsp 8'h02.
  - ab=00, dir=1 → write 1, rsp 8'h04.
  - ab=11 → only 2 starts, rsp 8'h0B.
- Backpressure: hold rsp_ready_i=0 for 10 cycles → rsp_valid_o and rsp_data_o stable; req_ready_o=0; a new req_valid_i is not accepted.
- Async reset asserted after 3 bits of op 01 → outputs zero immediately without a clock; after release, no response appears; a fresh op 10 completes normally.

Source files
------------

// File: rtl/owm_byte_seq.sv
// Byte/triplet sequencer in front of the 1-wire bit-level master core.
// Splits reset/write/read/search requests into single-bit core commands and returns one response each.
module owm_byte_seq (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic [1:0] req_op_i,
  input  logic [7:0] req_data_i,
  output logic       rsp_valid_o,
  input  logic       rsp_ready_i,
  output logic [7:0] rsp_data_o,
  output logic       rsp_presence_o,
  output logic       owm_start_o,
  output logic [2:0] owm_cmd_o,
  output logic       owm_wrdat_o,
  input  logic       owm_ready_i,
  input  logic       owm_presence_i,
  input  logic       owm_rddat_i
);

  localparam logic [1:0] OP_RST  = 2'b00;
  localparam logic [1:0] OP_WR   = 2'b01;
  localparam logic [1:0] OP_RD   = 2'b10;
  localparam logic [1:0] OP_SRCH = 2'b11;

  localparam logic [2:0] CMD_RST = 3'd0;
  localparam logic [2:0] CMD_WR  = 3'd1;
  localparam logic [2:0] CMD_RD  = 3'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_RESP
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] op_q;
  logic [7:0] data_q;
  logic [6:0] sh_q;
  logic       a_q, b_q;
  logic [2:0] bit_cnt_q;

  logic       accept;
  logic       bit_done;
  logic       last_bit;
  logic       load_cmd;
  logic [2:0] cmd_d;
  logic       wrdat_d;
  logic [7:0] rsp_data_d;
  logic       rsp_pres_d;

  // Search direction from the id/complement pair; ab=11 never reaches a write.
  function automatic logic triplet_dir(input logic a, input logic b, input logic dir);
    case ({a, b})
      2'b01:   triplet_dir = 1'b0;
      2'b10:   triplet_dir = 1'b1;
      default: triplet_dir = dir;
    endcase
  endfunction

  assign accept   = (state_q == S_IDLE) && req_valid_i;
  assign bit_done = (state_q == S_WAIT_DONE) && owm_ready_i;
  assign load_cmd = accept || (bit_done && !last_bit);

  always_comb begin
    last_bit = 1'b0;
    case (op_q)
      OP_RST:  last_bit = 1'b1;
      OP_WR,
      OP_RD:   last_bit = (bit_cnt_q == 3'd7);
      OP_SRCH: last_bit = (bit_cnt_q == 3'd2) || ((bit_cnt_q == 3'd1) && a_q && owm_rddat_i);
      default: last_bit = 1'b1;
    endcase
  end

  // Command for the bit about to be issued, registered as ISSUE is entered
  always_comb begin
    cmd_d   = CMD_RST;
    wrdat_d = 1'b0;
    if (state_q == S_IDLE) begin
      case (req_op_i)
        OP_RST:  cmd_d = CMD_RST;
        OP_WR: begin
          cmd_d   = CMD_WR;
          wrdat_d = req_data_i[0];
        end
        default: cmd_d = CMD_RD;
      endcase
    end else begin
      case (op_q)
        OP_WR: begin
          cmd_d   = CMD_WR;
          wrdat_d = data_q[bit_cnt_q + 3'd1];
        end
        OP_RD:   cmd_d = CMD_RD;
        OP_SRCH: begin
          if (bit_cnt_q == 3'd0) begin
            cmd_d = CMD_RD;
          end else begin
            cmd_d   = CMD_WR;
            wrdat_d = triplet_dir(a_q, owm_rddat_i, data_q[0]);
          end
        end
        default: cmd_d = CMD_RST;
      endcase
    end
  end

  always_comb begin
    rsp_data_d = 8'h00;
    rsp_pres_d = 1'b0;
    case (op_q)
      OP_RST:  rsp_pres_d = owm_presence_i;
      OP_WR:   rsp_data_d = data_q;
      OP_RD:   rsp_data_d = {owm_rddat_i, sh_q};
      OP_SRCH: begin
        if (bit_cnt_q == 3'd1)
          rsp_data_d = {4'b0000, 1'b1, 1'b0, owm_rddat_i, a_q};
        else
          rsp_data_d = {4'b0000, 1'b0, owm_wrdat_o, b_q, a_q};
      end
      default: rsp_data_d = 8'h00;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (req_valid_i) state_d = S_ISSUE;
      S_ISSUE:     if (owm_ready_i) state_d = S_WAIT_BUSY;
      S_WAIT_BUSY: if (!owm_ready_i) state_d = S_WAIT_DONE;
      S_WAIT_DONE: if (owm_ready_i) state_d = last_bit ? S_RESP : S_ISSUE;
      S_RESP:      if (rsp_ready_i) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bit_cnt_q      <= 3'd0;
      owm_cmd_o      <= CMD_RST;
      owm_wrdat_o    <= 1'b0;
      rsp_data_o     <= 8'h00;
      rsp_presence_o <= 1'b0;
    end else begin
      if (accept)
        bit_cnt_q <= 3'd0;
      else if (bit_done && !last_bit)
        bit_cnt_q <= bit_cnt_q + 3'd1;
      if (load_cmd) begin
        owm_cmd_o   <= cmd_d;
        owm_wrdat_o <= wrdat_d;
      end
      if (bit_done && last_bit) begin
        rsp_data_o     <= rsp_data_d;
        rsp_presence_o <= rsp_pres_d;
      end
    end
  end

  // Request payload and sampled bits; only meaningful between accept and response
  always_ff @(posedge clk_i) begin
    if (accept) begin
      op_q   <= req_op_i;
      data_q <= req_data_i;
      sh_q   <= 7'd0;
    end else if (bit_done) begin
      if (op_q == OP_RD)
        sh_q <= {owm_rddat_i, sh_q[6:1]};
      if (op_q == OP_SRCH && bit_cnt_q == 3'd0)
        a_q <= owm_rddat_i;
      if (op_q == OP_SRCH && bit_cnt_q == 3'd1)
        b_q <= owm_rddat_i;
    end
  end

  always_comb begin
    req_ready_o = (state_q == S_IDLE);
    rsp_valid_o = (state_q == S_RESP);
    owm_start_o = (state_q == S_ISSUE) && owm_ready_i;
  end

endmodule

// File: tb/tb_owm_byte_seq.sv
// Bench for owm_byte_seq: table of byte requests against a behavioural 1-wire core,
// plus hand-written latency, backpressure and mid-byte reset sequences.
module tb_owm_byte_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_op = 2'b00;
  logic [7:0] req_data = 8'h00;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic       rsp_pres;
  logic       owm_start;
  logic [2:0] owm_cmd;
  logic       owm_wrdat;
  logic       core_ready = 1'b1;
  logic       core_pres = 1'b0;
  logic       core_rddat = 1'b0;

  owm_byte_seq dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_op_i       (req_op),
    .req_data_i     (req_data),
    .rsp_valid_o    (rsp_valid),
    .rsp_ready_i    (rsp_ready),
    .rsp_data_o     (rsp_data),
    .rsp_presence_o (rsp_pres),
    .owm_start_o    (owm_start),
    .owm_cmd_o      (owm_cmd),
    .owm_wrdat_o    (owm_wrdat),
    .owm_ready_i    (core_ready),
    .owm_presence_i (core_pres),
    .owm_rddat_i    (core_rddat)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Core model settings written by the stimulus process
  int          busy_max_v = 4;
  logic [15:0] rd_pat_v = 16'h0000;
  logic        pres_v = 1'b0;
  int          rd_base = 0;

  // Core model state
  int          starts = 0;
  int          bad_start = 0;
  int          rd_ptr = 0;
  int          busy_cnt = 0;
  logic [2:0]  pend_cmd = 3'd0;
  logic [2:0]  log_cmd [0:255];
  logic        log_wr  [0:255];
  logic [3:0]  rd_ix;

  assign rd_ix = 4'(rd_ptr - rd_base);

  always @(posedge clk) begin
    if (owm_start) begin
      log_cmd[starts[7:0]] <= owm_cmd;
      log_wr[starts[7:0]]  <= owm_wrdat;
      if (!core_ready) bad_start <= bad_start + 1;
      starts     <= starts + 1;
      core_ready <= 1'b0;
      busy_cnt   <= int'($urandom_range(busy_max_v, 1));
      pend_cmd   <= owm_cmd;
    end else if (!core_ready) begin
      if (busy_cnt <= 1) begin
        core_ready <= 1'b1;
        core_pres  <= pres_v;
        if (pend_cmd == 3'd2) begin
          core_rddat <= rd_pat_v[rd_ix];
          rd_ptr     <= rd_ptr + 1;
        end
      end else begin
        busy_cnt <= busy_cnt - 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    string        name;
    logic [1:0]   op;
    logic [7:0]   data;
    logic [15:0]  rd_pat;
    logic         pres;
    int           busy_max;
    int           n_starts;
    logic [7:0][2:0] cmds;
    logic [7:0]   wr;
    logic [7:0]   rsp;
    logic         rsp_pres;
  } vec_t;

  localparam logic [23:0] CMDS_RST = 24'h000000;
  localparam logic [23:0] CMDS_WR  = {8{3'd1}};
  localparam logic [23:0] CMDS_RD  = {8{3'd2}};
  localparam logic [23:0] CMDS_TRI = {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd2};
  localparam logic [23:0] CMDS_ERR = {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd2, 3'd2};

  vec_t vecs [10];

  task automatic wait_rsp(input string name, output logic ok);
    int t;
    t = 0;
    while (!rsp_valid && t < 3000) begin
      @(negedge clk);
      t++;
    end
    ok = rsp_valid;
    if (!ok) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic take_rsp(input string name);
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk({name, "_idle_after_take"}, {30'd0, rsp_valid, req_ready}, 32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    int base;
    logic ok;
    logic [7:0][2:0] act_cmds;
    logic [7:0] act_wr;
    busy_max_v = v.busy_max;
    rd_pat_v   = v.rd_pat;
    pres_v     = v.pres;
    rd_base    = rd_ptr;
    base       = starts;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = v.op;
    req_data  = v.data;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk({v.name, "_start_latency"}, {31'd0, owm_start}, 32'd1);
    wait_rsp(v.name, ok);
    if (ok) begin
      chk({v.name, "_rsp_data"}, {24'd0, rsp_data}, {24'd0, v.rsp});
      chk({v.name, "_rsp_presence"}, {31'd0, rsp_pres}, {31'd0, v.rsp_pres});
      chk({v.name, "_num_starts"}, 32'(starts - base), 32'(v.n_starts));
      act_cmds = '0;
      act_wr   = '0;
      for (int k = 0; k < 8; k++) begin
        if (k < starts - base) begin
          act_cmds[k] = log_cmd[8'(base + k)];
          if (v.cmds[k] == 3'd1) act_wr[k] = log_wr[8'(base + k)];
        end
      end
      chk({v.name, "_cmd_seq"}, {8'd0, act_cmds}, {8'd0, v.cmds});
      chk({v.name, "_wrdat_seq"}, {24'd0, act_wr}, {24'd0, v.wr});
      take_rsp(v.name);
    end
  endtask

  initial begin
    int   base;
    logic ok;
    logic stable;
    logic seen;
    vec_t v;

    vecs[0] = '{"rst_p1",   2'b00, 8'h00, 16'h0000, 1'b1, 4,  1, CMDS_RST, 8'h00, 8'h00, 1'b1};
    vecs[1] = '{"rst_p0",   2'b00, 8'h00, 16'h0000, 1'b0, 4,  1, CMDS_RST, 8'h00, 8'h00, 1'b0};
    vecs[2] = '{"wr_a5",    2'b01, 8'hA5, 16'h0000, 1'b1, 4,  8, CMDS_WR,  8'hA5, 8'hA5, 1'b0};
    vecs[3] = '{"wr_3c",    2'b01, 8'h3C, 16'h0000, 1'b1, 3,  8, CMDS_WR,  8'h3C, 8'h3C, 1'b0};
    vecs[4] = '{"rd_c6",    2'b10, 8'h00, 16'h00C6, 1'b1, 20, 8, CMDS_RD,  8'h00, 8'hC6, 1'b0};
    vecs[5] = '{"tri_10d0", 2'b11, 8'h00, 16'h0001, 1'b1, 4,  3, CMDS_TRI, 8'h04, 8'h05, 1'b0};
    vecs[6] = '{"tri_01d1", 2'b11, 8'h01, 16'h0002, 1'b1, 4,  3, CMDS_TRI, 8'h00, 8'h02, 1'b0};
    vecs[7] = '{"tri_00d1", 2'b11, 8'h01, 16'h0000, 1'b1, 4,  3, CMDS_TRI, 8'h04, 8'h04, 1'b0};
    vecs[8] = '{"tri_00d0", 2'b11, 8'h00, 16'h0000, 1'b1, 4,  3, CMDS_TRI, 8'h00, 8'h00, 1'b0};
    vecs[9] = '{"tri_11",   2'b11, 8'h01, 16'h0003, 1'b1, 4,  2, CMDS_ERR, 8'h00, 8'h0B, 1'b0};

    repeat (3) @(negedge clk);
    chk("reset_outputs",
        {19'd0, req_ready, rsp_valid, rsp_data, rsp_pres, owm_start, owm_cmd, owm_wrdat},
        {19'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0});
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Backpressure: response held, new request refused
    busy_max_v = 3;
    pres_v     = 1'b1;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 2'b01;
    req_data  = 8'h5A;
    @(posedge clk);
    #1;
    req_op = 2'b00;
    wait_rsp("bp", ok);
    if (ok) begin
      base   = starts;
      stable = 1'b1;
      for (int c = 0; c < 10; c++) begin
        if (!(rsp_valid && rsp_data == 8'h5A && !req_ready)) stable = 1'b0;
        @(negedge clk);
      end
      req_valid = 1'b0;
      chk("bp_hold_stable", {31'd0, stable}, 32'd1);
      chk("bp_rsp_data", {24'd0, rsp_data}, 32'h5A);
      chk("bp_no_new_start", 32'(starts - base), 32'd0);
      take_rsp("bp");
      @(negedge clk);
      chk("bp_no_late_start", 32'(starts - base), 32'd0);
    end

    // Asynchronous reset in the middle of a write byte
    busy_max_v = 4;
    base = starts;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 2'b01;
    req_data  = 8'hFF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    for (int t = 0; t < 500 && starts < base + 4; t++) @(negedge clk);
    chk("mid_reset_reached_bit4", {31'd0, (starts >= base + 4)}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_reset_async_outputs",
        {19'd0, req_ready, rsp_valid, rsp_data, rsp_pres, owm_start, owm_cmd, owm_wrdat},
        {19'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0});
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    chk("mid_reset_no_response", {31'd0, seen}, 32'd0);
    v = '{"rd_after_reset", 2'b10, 8'h00, 16'h003B, 1'b1, 5, 8, CMDS_RD, 8'h00, 8'h3B, 1'b0};
    run_vec(v);

    chk("no_start_while_busy", 32'(bad_start), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
